alu_op_sequencer: RTL and testbench

// Upstream issue stage for the combinational 4-bit ALU. Buffers operation requests in a

---
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Summary  : Request FIFO plus a three-state issue FSM that feeds a
//            combinational ALU. The result is registered into a downstream
//            valid/ready port and into a running accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic [WIDTH-1:0] acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = SEL_W + 2 * WIDTH + 1;
  localparam logic [SEL_W-1:0] SEL_LAST_LEGAL = SEL_W'(4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, out_result_q, acc_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             out_illegal_q;

  logic             fifo_empty, fifo_full, push, pop;
  logic [EW-1:0]    head;
  logic [SEL_W-1:0] head_sel;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_use_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state_q == S_IDLE) && !fifo_empty;

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign head_sel     = head[EW-1 -: SEL_W];
  assign head_a       = head[2*WIDTH -: WIDTH];
  assign head_b       = head[WIDTH -: WIDTH];
  assign head_use_acc = head[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_sel, in_a, in_b, in_use_acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      out_result_q  <= '0;
      acc_q         <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      // ALU operands are latched on entry to EXEC and held until the next pop.
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        alu_a_q   <= head_use_acc ? acc_q : head_a;
        alu_b_q   <= head_b;
        alu_sel_q <= head_sel;
      end
      if (state_q == S_EXEC) begin
        out_result_q  <= alu_result;
        acc_q         <= alu_result;
        out_illegal_q <= (alu_sel_q > SEL_LAST_LEGAL);
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign out_valid   = (state_q == S_DONE);
  assign out_result  = out_result_q;
  assign out_illegal = out_illegal_q;
  assign acc         = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Summary  : Directed bench for alu_op_sequencer with a behavioural 4-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_sel = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_use_acc = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result, out_result, acc;
  logic [2:0] alu_sel;
  logic       out_valid, out_illegal;
  logic       out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_sequencer #(.WIDTH(4), .SEL_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .acc(acc)
  );

  always #5 clk = ~clk;

  // Reference ALU; illegal opcodes return a ^ b so pass-through is observable.
  always_comb begin
    alu_result = alu_a ^ alu_b;
    case (alu_sel)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [2:0] s, input logic [3:0] a,
                         input logic [3:0] b, input logic u);
    in_valid = 1'b1; in_sel = s; in_a = a; in_b = b; in_use_acc = u;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if ({alu_a, alu_b, alu_sel} !== 11'd0) begin
      n_fail++; $display("FAIL reset_alu: got a=%b b=%b sel=%b want 0", alu_a, alu_b, alu_sel);
    end
    n_tests++;
    if ({out_result, acc, out_illegal} !== 9'd0) begin
      n_fail++; $display("FAIL reset_out: got res=%b acc=%b ill=%b want 0", out_result, acc, out_illegal);
    end
    step();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    push_op(3'b000, 4'b0011, 4'b0001, 1'b0);
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early: out_valid got %b want 0", out_valid); end
    step();
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
    n_tests++;
    if (out_result !== 4'b0100 || out_illegal !== 1'b0 || acc !== 4'b0100) begin
      n_fail++; $display("FAIL add_result: got res=%b ill=%b acc=%b want 0100 0 0100", out_result, out_illegal, acc);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_consume: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_acc_chain();
    bit ok;
    out_ready = 1'b1;
    push_op(3'b000, 4'b0011, 4'b0001, 1'b0);
    push_op(3'b001, 4'b1111, 4'b0110, 1'b1);
    wait_valid(ok);
    n_tests++;
    if (!ok || out_result !== 4'b0100) begin
      n_fail++; $display("FAIL chain_first: got valid=%b res=%b want 1 0100", ok, out_result);
    end
    step();
    wait_valid(ok);
    n_tests++;
    if (!ok || out_result !== 4'b1110 || acc !== 4'b1110) begin
      n_fail++; $display("FAIL chain_second: got valid=%b res=%b acc=%b want 1 1110 1110", ok, out_result, acc);
    end
    n_tests++;
    if (alu_a !== 4'b0100 || alu_b !== 4'b0110 || alu_sel !== 3'b001) begin
      n_fail++; $display("FAIL chain_alu_in: got a=%b b=%b sel=%b want 0100 0110 001", alu_a, alu_b, alu_sel);
    end
    step();
  endtask

  task automatic test_logic();
    bit ok;
    logic [2:0] sels [3];
    logic [3:0] exps [3];
    sels[0] = 3'b010; exps[0] = 4'b1000;
    sels[1] = 3'b011; exps[1] = 4'b1110;
    sels[2] = 3'b100; exps[2] = 4'b0011;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_op(sels[k], 4'b1100, 4'b1010, 1'b0);
      wait_valid(ok);
      n_tests++;
      if (!ok || out_result !== exps[k] || out_illegal !== 1'b0) begin
        n_fail++; $display("FAIL logic_sel%b: got valid=%b res=%b ill=%b want 1 %b 0", sels[k], ok, out_result, out_illegal, exps[k]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit extra;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 1", i, in_ready); end
      push_op(3'b000, 4'(i), 4'b0001, 1'b0);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    in_valid = 1'b1; in_sel = 3'b000; in_a = 4'b1111; in_b = 4'b0001; in_use_acc = 1'b0;
    step(); step(); step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_result !== 4'b0010) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b res=%b want 1 0010", out_valid, out_result);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_valid(ok);
      n_tests++;
      if (!ok || out_result !== 4'(i + 1)) begin
        n_fail++; $display("FAIL bp_order_%0d: got valid=%b res=%b want 1 %b", i, ok, out_result, 4'(i + 1));
      end
      step();
    end
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra = 1'b1;
      step();
    end
    n_tests++;
    if (extra !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: extra result seen=%b want 0", extra); end
  endtask

  task automatic test_illegal();
    bit ok;
    out_ready = 1'b1;
    push_op(3'b111, 4'b0101, 4'b0011, 1'b0);
    wait_valid(ok);
    n_tests++;
    if (!ok || out_illegal !== 1'b1 || out_result !== 4'b0110 || acc !== 4'b0110) begin
      n_fail++; $display("FAIL illegal_111: got valid=%b ill=%b res=%b acc=%b want 1 1 0110 0110", ok, out_illegal, out_result, acc);
    end
    n_tests++;
    if (alu_sel !== 3'b111) begin n_fail++; $display("FAIL illegal_sel: got %b want 111", alu_sel); end
    step();
    push_op(3'b000, 4'b0001, 4'b0001, 1'b0);
    wait_valid(ok);
    n_tests++;
    if (!ok || out_illegal !== 1'b0 || out_result !== 4'b0010) begin
      n_fail++; $display("FAIL illegal_clear: got valid=%b ill=%b res=%b want 1 0 0010", ok, out_illegal, out_result);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b0;
    push_op(3'b000, 4'b0111, 4'b0001, 1'b0);
    push_op(3'b000, 4'b0010, 4'b0011, 1'b0);
    push_op(3'b011, 4'b0101, 4'b0010, 1'b0);
    push_op(3'b001, 4'b1001, 4'b0001, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0 || alu_a !== 4'b0010 || acc !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_exec: got valid=%b alu_a=%b acc=%b want 0 0010 1000", out_valid, alu_a, acc);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({alu_a, alu_b, alu_sel, out_result, acc, out_valid, out_illegal} !== 21'd0) begin
      n_fail++; $display("FAIL rstmid_async: got a=%b b=%b sel=%b res=%b acc=%b v=%b ill=%b want 0",
                         alu_a, alu_b, alu_sel, out_result, acc, out_valid, out_illegal);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || acc !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_flushed: got valid_seen=%b acc=%b want 0 0000", seen, acc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_acc_chain();
    test_logic();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
